uart_fifo_bridge: RTL and testbench

- Buffering stage between the bus-side register interface and the UART core (uart_v2).
- TX path: the host pushes bytes into a TX FIFO. A pump FSM pops one byte at a time and issues a one-cycle transmit pulse to the UART once the UART is idle.
- RX path: each one-cycle received pulse from the UART pushes rx_byte into an RX FIFO, which the host drains with first-word-fall-through reads.
- Sticky overflow flags record any dropped bytes in either direction.

---
 rtl/uart_fifo_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
// Buffering stage between the host register interface and the UART core.
//   TX path : host pushes bytes into a TX FIFO. A pump FSM pops one byte at
//             a time and issues a one-cycle transmit strobe to the UART
//             whenever the UART is idle.
//   RX path : every uart_received strobe pushes uart_rx_byte into an RX FIFO,
//             which the host drains with first-word-fall-through reads.
//   Sticky tx_overflow / rx_overflow record dropped bytes; clear_overflow
//   clears both unless a new drop happens in the same cycle.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   tx_wr_en, tx_wr_data             host write into the TX FIFO
//   tx_full, tx_count                TX FIFO status
//   rx_rd_en, rx_rd_data             host pop / head of the RX FIFO
//   rx_empty, rx_count               RX FIFO status
//   rx_overflow, tx_overflow         sticky drop flags
//   clear_overflow                   clears both sticky flags
//   uart_transmit, uart_tx_byte      transmit strobe and byte to the UART
//   uart_is_transmitting             UART busy indicator
//   uart_received, uart_rx_byte      receive strobe and byte from the UART
module uart_fifo_bridge #(
    parameter int DEPTH_BITS    = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_wr_en,
    input  logic [7:0]            tx_wr_data,
    output logic                  tx_full,
    output logic [DEPTH_BITS:0]   tx_count,
    input  logic                  rx_rd_en,
    output logic [7:0]            rx_rd_data,
    output logic                  rx_empty,
    output logic [DEPTH_BITS:0]   rx_count,
    output logic                  rx_overflow,
    output logic                  tx_overflow,
    input  logic                  clear_overflow,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting,
    input  logic                  uart_received,
    input  logic [7:0]            uart_rx_byte
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    // One extra bit so the counter never wraps for small START_TIMEOUT values.
    localparam int TW    = $clog2(START_TIMEOUT + 1) + 1;

    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO = {DEPTH_BITS{1'b0}};
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS:0]   CNT_ZERO = {(DEPTH_BITS+1){1'b0}};
    localparam logic [DEPTH_BITS:0]   CNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [TW-1:0]         TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]         TMR_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]         TMR_LOAD = TW'(START_TIMEOUT);

    typedef enum logic [1:0] {
        P_IDLE       = 2'd0,
        P_WAIT_START = 2'd1,
        P_WAIT_DONE  = 2'd2
    } pump_state_t;

    // TX FIFO state
    logic [7:0]            tx_mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] tx_wr_ptr_r;
    logic [DEPTH_BITS-1:0] tx_rd_ptr_r;
    logic [DEPTH_BITS:0]   tx_count_r;
    logic                  tx_overflow_r;

    // RX FIFO state
    logic [7:0]            rx_mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] rx_wr_ptr_r;
    logic [DEPTH_BITS-1:0] rx_rd_ptr_r;
    logic [DEPTH_BITS:0]   rx_count_r;
    logic                  rx_overflow_r;

    // Pump FSM state
    pump_state_t           pump_state_r;
    logic [TW-1:0]         timer_r;
    logic                  uart_transmit_r;
    logic [7:0]            uart_tx_byte_r;

    logic tx_full_s, tx_empty_s, tx_pop_s, tx_push_s, tx_drop_s;
    logic rx_full_s, rx_empty_s, rx_pop_s, rx_push_s, rx_drop_s;

    assign tx_full_s  = (tx_count_r == CNT_FULL);
    assign tx_empty_s = (tx_count_r == CNT_ZERO);
    assign rx_full_s  = (rx_count_r == CNT_FULL);
    assign rx_empty_s = (rx_count_r == CNT_ZERO);

    // The pump pops in the same cycle it launches the strobe, so a pop frees
    // a slot that a simultaneous host write may take even when full.
    assign tx_pop_s  = (pump_state_r == P_IDLE) && !tx_empty_s && !uart_is_transmitting;
    assign tx_push_s = tx_wr_en && (!tx_full_s || tx_pop_s);
    assign tx_drop_s = tx_wr_en && tx_full_s && !tx_pop_s;

    // Reads of an empty FIFO are ignored, so an empty push+read is push only.
    assign rx_pop_s  = rx_rd_en && !rx_empty_s;
    assign rx_push_s = uart_received && (!rx_full_s || rx_pop_s);
    assign rx_drop_s = uart_received && rx_full_s && !rx_pop_s;

    assign tx_full       = tx_full_s;
    assign tx_count      = tx_count_r;
    assign tx_overflow   = tx_overflow_r;
    assign rx_empty      = rx_empty_s;
    assign rx_count      = rx_count_r;
    assign rx_overflow   = rx_overflow_r;
    assign rx_rd_data    = rx_mem_r[rx_rd_ptr_r];
    assign uart_transmit = uart_transmit_r;
    assign uart_tx_byte  = uart_tx_byte_r;

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
            tx_count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_r[i] <= 8'h00;
            end
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= tx_wr_data;
                tx_wr_ptr_r           <= tx_wr_ptr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_r <= PTR_ZERO;
            rx_rd_ptr_r <= PTR_ZERO;
            rx_count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_r[i] <= 8'h00;
            end
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= uart_rx_byte;
                rx_wr_ptr_r           <= rx_wr_ptr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sticky overflow flags; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow_r <= 1'b0;
            rx_overflow_r <= 1'b0;
        end else begin
            if (tx_drop_s) begin
                tx_overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                tx_overflow_r <= 1'b0;
            end
            if (rx_drop_s) begin
                rx_overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                rx_overflow_r <= 1'b0;
            end
        end
    end

    // Pump FSM: launch a byte, wait for the UART to go busy (or time out,
    // treating the byte as consumed), then wait for the UART to finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            pump_state_r    <= P_IDLE;
            timer_r         <= TMR_ZERO;
            uart_transmit_r <= 1'b0;
            uart_tx_byte_r  <= 8'h00;
        end else begin
            case (pump_state_r)
                P_IDLE: begin
                    uart_transmit_r <= 1'b0;
                    if (tx_pop_s) begin
                        uart_tx_byte_r  <= tx_mem_r[tx_rd_ptr_r];
                        uart_transmit_r <= 1'b1;
                        timer_r         <= TMR_LOAD;
                        pump_state_r    <= P_WAIT_START;
                    end
                end
                P_WAIT_START: begin
                    uart_transmit_r <= 1'b0;
                    if (uart_is_transmitting) begin
                        pump_state_r <= P_WAIT_DONE;
                    end else if (timer_r <= TMR_ONE) begin
                        // UART never acknowledged (reset or divider change).
                        timer_r      <= TMR_ZERO;
                        pump_state_r <= P_IDLE;
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                P_WAIT_DONE: begin
                    uart_transmit_r <= 1'b0;
                    if (!uart_is_transmitting) begin
                        pump_state_r <= P_IDLE;
                    end
                end
                default: begin
                    uart_transmit_r <= 1'b0;
                    pump_state_r    <= P_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: a UART behavioural model drives
// the busy line, expected TX/RX bytes are queued by the stimulus and popped
// by monitors when the DUT presents a transmit strobe or services a read.
module tb_uart_fifo_bridge;

    localparam int DB    = 4;
    localparam int ST    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_wr_en = 1'b0;
    logic [7:0]    tx_wr_data = 8'h00;
    logic          tx_full;
    logic [DB:0]   tx_count;
    logic          rx_rd_en = 1'b0;
    logic [7:0]    rx_rd_data;
    logic          rx_empty;
    logic [DB:0]   rx_count;
    logic          rx_overflow;
    logic          tx_overflow;
    logic          clear_overflow = 1'b0;
    logic          uart_transmit;
    logic [7:0]    uart_tx_byte;
    logic          uart_is_transmitting = 1'b0;
    logic          uart_received = 1'b0;
    logic [7:0]    uart_rx_byte = 8'h00;

    uart_fifo_bridge #(.DEPTH_BITS(DB), .START_TIMEOUT(ST)) dut (
        .clk(clk), .rst(rst),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_count(tx_count),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
        .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .tx_overflow(tx_overflow),
        .clear_overflow(clear_overflow),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting),
        .uart_received(uart_received), .uart_rx_byte(uart_rx_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_tx_q [$];   // bytes expected on uart_transmit, in order
    logic [7:0] rx_q     [$];   // reference RX FIFO contents
    bit         rx_ovf_m = 1'b0;

    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;

    // UART model controls
    bit force_busy = 1'b0;
    bit never_busy = 1'b0;
    bit rand_len   = 1'b0;
    int busy_len   = 100;
    bit busy_norm  = 1'b0;
    bit pend       = 1'b0;
    int bcnt       = 0;
    int fall_cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // UART model: goes busy one cycle after a strobe and stays busy a while.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                busy_norm = 1'b1;
                bcnt = rand_len ? int'($urandom_range(1, 6)) : busy_len;
                pend = 1'b0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    busy_norm = 1'b0;
                    fall_cyc  = cyc;
                end
            end
            if (uart_transmit && !never_busy && !rst) pend = 1'b1;
            uart_is_transmitting = busy_norm || force_busy;
        end
    end

    // TX monitor: every strobe must carry the next expected byte.
    initial begin : tx_mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else if (uart_transmit) begin
                check("pulse_width", prev, 0);
                if (!force_busy) check("busy_at_pulse", uart_is_transmitting, 0);
                check("tx_exp_avail", exp_tx_q.size() > 0, 1);
                if (exp_tx_q.size() > 0) check("tx_byte", uart_tx_byte, exp_tx_q.pop_front());
                prev_pulse_cyc = last_pulse_cyc;
                last_pulse_cyc = cyc;
                pulse_cnt++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    // RX monitor: every serviced read must present the reference head.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (!rst && rx_rd_en && !rx_empty) begin
                check("rx_exp_avail", rx_q.size() > 0, 1);
                if (rx_q.size() > 0) check("rx_rd_data", rx_rd_data, rx_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_wr_en = 1'b1;
        tx_wr_data = b;
        if (exp_tx_q.size() < DEPTH) exp_tx_q.push_back(b);
        @(posedge clk); #1;
        tx_wr_en = 1'b0;
    endtask

    // One RX-side cycle, checked against the reference FIFO rules.
    task automatic rx_cycle(input bit rcv, input logic [7:0] b, input bit rd, input bit clr);
        int s;
        bit pop_w, acc, ovf;
        s     = rx_q.size();
        pop_w = rd && (s > 0);
        acc   = rcv && ((s < DEPTH) || pop_w);
        ovf   = rcv && (s == DEPTH) && !pop_w;
        uart_received = rcv; uart_rx_byte = b; rx_rd_en = rd; clear_overflow = clr;
        @(posedge clk); #1;
        uart_received = 1'b0; rx_rd_en = 1'b0; clear_overflow = 1'b0;
        if (acc) rx_q.push_back(b);
        if (ovf) rx_ovf_m = 1'b1;
        else if (clr) rx_ovf_m = 1'b0;
        check("rx_count", rx_count, rx_q.size());
        check("rx_empty", rx_empty, rx_q.size() == 0);
        check("rx_overflow", rx_overflow, rx_ovf_m);
    endtask

    task automatic wait_tx_drain(input string name, input int bound);
        int k;
        k = 0;
        while (exp_tx_q.size() > 0 && k < bound) begin @(posedge clk); #1; k++; end
        check(name, exp_tx_q.size(), 0);
    endtask

    initial begin
        int base, gap, k;

        // Reset state
        idle(3);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_transmit", uart_transmit, 0);
        check("rst_tx_byte", uart_tx_byte, 0);
        check("rst_rx_rd_data", rx_rd_data, 0);
        check("rst_tx_ovf", tx_overflow, 0);
        check("rst_rx_ovf", rx_overflow, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("idle_tx_count", tx_count, 0);
            check("idle_rx_count", rx_count, 0);
            check("idle_rx_empty", rx_empty, 1);
            check("idle_transmit", uart_transmit, 0);
        end

        // Single-byte latency, then a second byte held off by busy
        busy_len = 100;
        tx_write(8'hA5);
        check("lat_count_e0", tx_count, 1);
        idle(1);
        check("lat_transmit_e1", uart_transmit, 1);
        check("lat_byte_e1", uart_tx_byte, 8'hA5);
        check("lat_count_e1", tx_count, 0);
        idle(1);
        check("lat_transmit_e2", uart_transmit, 0);
        tx_write(8'h3C);
        k = 0;
        while (pulse_cnt < 2 && k < 300) begin idle(1); k++; end
        check("second_pulse_seen", pulse_cnt >= 2, 1);
        check("second_pulse_after_idle", last_pulse_cyc - fall_cyc, 2);
        k = 0;
        while ((busy_norm || pend) && k < 300) begin idle(1); k++; end
        check("busy_released", busy_norm, 0);
        idle(5);

        // TX overflow with the UART held busy
        force_busy = 1'b1;
        idle(3);
        for (int i = 0; i < 17; i++) begin
            tx_write(8'(i));
            if (i == 15) begin
                check("txf_full_16", tx_full, 1);
                check("txf_count_16", tx_count, 16);
                check("txf_ovf_16", tx_overflow, 0);
            end
        end
        check("txf_ovf_17", tx_overflow, 1);
        check("txf_count_17", tx_count, 16);
        busy_len = 3;
        force_busy = 1'b0;
        wait_tx_drain("txf_drain", 1000);
        idle(40);
        check("txf_count_end", tx_count, 0);
        clear_overflow = 1'b1;
        idle(1);
        clear_overflow = 1'b0;
        check("txf_ovf_cleared", tx_overflow, 0);

        // RX overflow and in-order drain
        for (int i = 0; i < 16; i++) rx_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        rx_cycle(1'b1, 8'h20, 1'b0, 1'b0);
        check("rxf_count_16", rx_count, 16);
        check("rxf_ovf", rx_overflow, 1);
        for (int i = 0; i < 16; i++) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        rx_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("rxf_ovf_cleared", rx_overflow, 0);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 16; i++) rx_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        rx_cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("rxs_count", rx_count, 16);
        check("rxs_no_ovf", rx_overflow, 0);
        for (int i = 0; i < 15; i++) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("rxs_last_head", rx_rd_data, 8'h55);
        rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised RX traffic
        for (int i = 0; i < 300; i++) begin
            bit rcv, rd;
            rcv = (i < 150) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 3);
            rd  = (i < 150) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 6);
            rx_cycle(rcv, 8'($urandom_range(0, 255)), rd, $urandom_range(0, 9) == 0);
        end
        while (rx_q.size() > 0) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised TX traffic with variable UART busy time
        rand_len = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && exp_tx_q.size() < DEPTH - 1)
                tx_write(8'($urandom_range(0, 255)));
            else
                idle(1);
        end
        wait_tx_drain("rand_tx_drain", 2000);
        k = 0;
        while ((busy_norm || pend) && k < 50) begin idle(1); k++; end
        rand_len = 1'b0;
        idle(3);

        // Start timeout: UART never acknowledges
        never_busy = 1'b1;
        base = pulse_cnt;
        tx_write(8'h77);
        tx_write(8'h88);
        k = 0;
        while (pulse_cnt < base + 2 && k < 50) begin idle(1); k++; end
        check("timeout_two_pulses", pulse_cnt >= base + 2, 1);
        gap = last_pulse_cyc - prev_pulse_cyc;
        check("timeout_gap", (gap >= ST + 1) && (gap <= ST + 2), 1);
        idle(10);

        // Reset in the middle of a transfer
        rx_cycle(1'b1, 8'hAB, 1'b0, 1'b0);
        rx_cycle(1'b1, 8'hCD, 1'b0, 1'b0);
        base = pulse_cnt;
        tx_write(8'h91);
        tx_write(8'h92);
        tx_write(8'h93);
        k = 0;
        while (pulse_cnt <= base && k < 20) begin idle(1); k++; end
        check("midrst_first_pulse", pulse_cnt > base, 1);
        idle(1);
        rst = 1'b1;
        exp_tx_q.delete();
        rx_q.delete();
        rx_ovf_m = 1'b0;
        idle(1);
        check("midrst_tx_count", tx_count, 0);
        check("midrst_rx_count", rx_count, 0);
        check("midrst_rx_empty", rx_empty, 1);
        check("midrst_transmit", uart_transmit, 0);
        check("midrst_tx_full", tx_full, 0);
        rst = 1'b0;
        idle(30);
        check("end_tx_queue", exp_tx_q.size(), 0);
        check("end_tx_count", tx_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
